// File: rtl/decode_stage_pkg.sv
// Shared SPARC encodings, decode-stage state enum and decoded-field bundle.
package decode_stage_pkg;

    localparam logic [1:0] OP_FMT2 = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_FMT3 = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_ADD     = 6'b000000;
    localparam logic [5:0] OP3_AND     = 6'b000001;
    localparam logic [5:0] OP3_OR      = 6'b000010;
    localparam logic [5:0] OP3_XOR     = 6'b000011;
    localparam logic [5:0] OP3_SUB     = 6'b000100;
    localparam logic [5:0] OP3_ANDN    = 6'b000101;
    localparam logic [5:0] OP3_ORN     = 6'b000110;
    localparam logic [5:0] OP3_XNOR    = 6'b000111;
    localparam logic [5:0] OP3_ADDCC   = 6'b010000;
    localparam logic [5:0] OP3_ANDCC   = 6'b010001;
    localparam logic [5:0] OP3_ORCC    = 6'b010010;
    localparam logic [5:0] OP3_XORCC   = 6'b010011;
    localparam logic [5:0] OP3_SUBCC   = 6'b010100;
    localparam logic [5:0] OP3_SLL     = 6'b100101;
    localparam logic [5:0] OP3_SRL     = 6'b100110;
    localparam logic [5:0] OP3_SRA     = 6'b100111;
    localparam logic [5:0] OP3_JMPL    = 6'b111000;
    localparam logic [5:0] OP3_SAVE    = 6'b111100;
    localparam logic [5:0] OP3_RESTORE = 6'b111101;

    localparam logic [3:0] COND_N   = 4'h0;
    localparam logic [3:0] COND_E   = 4'h1;
    localparam logic [3:0] COND_LE  = 4'h2;
    localparam logic [3:0] COND_L   = 4'h3;
    localparam logic [3:0] COND_LEU = 4'h4;
    localparam logic [3:0] COND_CS  = 4'h5;
    localparam logic [3:0] COND_NEG = 4'h6;
    localparam logic [3:0] COND_VS  = 4'h7;
    localparam logic [3:0] COND_A   = 4'h8;
    localparam logic [3:0] COND_NE  = 4'h9;
    localparam logic [3:0] COND_G   = 4'hA;
    localparam logic [3:0] COND_GE  = 4'hB;
    localparam logic [3:0] COND_GU  = 4'hC;
    localparam logic [3:0] COND_CC  = 4'hD;
    localparam logic [3:0] COND_POS = 4'hE;
    localparam logic [3:0] COND_VC  = 4'hF;

    typedef enum logic [1:0] {
        ST_EMPTY      = 2'd0,
        ST_FULL       = 2'd1,
        ST_ANNUL_PEND = 2'd2
    } dec_state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [4:0]  rd;
        logic [3:0]  cond;
        logic        a;
        logic        i;
        logic [21:0] imm22;
        logic [12:0] simm13;
        logic [29:0] disp30;
        logic        illegal;
    } dec_fields_t;

    function automatic logic op3_implemented(input logic [5:0] op3);
        case (op3)
            OP3_ADD, OP3_AND, OP3_OR, OP3_XOR, OP3_SUB, OP3_ANDN, OP3_ORN,
            OP3_XNOR, OP3_ADDCC, OP3_ANDCC, OP3_ORCC, OP3_XORCC, OP3_SUBCC,
            OP3_SLL, OP3_SRL, OP3_SRA, OP3_JMPL, OP3_SAVE, OP3_RESTORE:
                op3_implemented = 1'b1;
            default:
                op3_implemented = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decoded-field bundle carried from the field extractor to the stage register.
interface decode_stage_if;
    import decode_stage_pkg::*;

    dec_fields_t fields;

    modport master (output fields);
    modport slave  (input  fields);
endinterface

// File: rtl/decode_stage_fields.sv
// Combinational SPARC field extraction and illegal-opcode check.
module inst_fields
    import decode_stage_pkg::*;
(
    input  logic [31:0]   inst_i,
    decode_stage_if.master fld
);

    always_comb begin
        fld.fields        = '0;
        fld.fields.op     = inst_i[31:30];
        fld.fields.rd     = inst_i[29:25];
        fld.fields.a      = inst_i[29];
        fld.fields.cond   = inst_i[28:25];
        fld.fields.op2    = inst_i[24:22];
        fld.fields.imm22  = inst_i[21:0];
        fld.fields.disp30 = inst_i[29:0];
        fld.fields.op3    = inst_i[24:19];
        fld.fields.i      = inst_i[13];
        fld.fields.simm13 = inst_i[12:0];
        // CALL and memory formats are always legal here; only formats 2 and 3 are screened
        case (inst_i[31:30])
            OP_FMT2: fld.fields.illegal = (inst_i[24:22] != OP2_SETHI) &&
                                          (inst_i[24:22] != OP2_BICC);
            OP_FMT3: fld.fields.illegal = !op3_implemented(inst_i[24:19]);
            default: fld.fields.illegal = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// SPARC decode stage: one-entry skid register with delay-slot annul handling.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fet_valid_in,
    output logic        fet_ready_out,
    input  logic [31:0] fet_inst_in,
    input  logic [31:0] fet_pc_in,
    output logic [4:0]  rf_rs1_out,
    output logic [4:0]  rf_rs2_out,
    input  logic [31:0] rf_data1_in,
    input  logic [31:0] rf_data2_in,
    input  logic        ex_kill_in,
    output logic        dec_valid_out,
    input  logic        dec_ready_in,
    output logic [1:0]  dec_op_out,
    output logic [2:0]  dec_op2_out,
    output logic [5:0]  dec_op3_out,
    output logic [4:0]  dec_rd_out,
    output logic [3:0]  dec_cond_out,
    output logic        dec_a_out,
    output logic        dec_i_out,
    output logic [21:0] dec_imm22_out,
    output logic [12:0] dec_simm13_out,
    output logic [29:0] dec_disp30_out,
    output logic [31:0] dec_valA_out,
    output logic [31:0] dec_valB_out,
    output logic [31:0] dec_PC_out,
    output logic        dec_illegal_out
);

    typedef struct packed {
        dec_fields_t f;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [31:0] pc;
    } entry_t;

    decode_stage_if fld_if ();

    inst_fields u_fields (
        .inst_i (fet_inst_in),
        .fld    (fld_if.master)
    );

    dec_state_e state_q;
    entry_t     entry_q;
    entry_t     entry_d;
    logic       fet_accept;

    assign rf_rs1_out    = fet_inst_in[18:14];
    assign rf_rs2_out    = fet_inst_in[4:0];
    assign dec_valid_out = (state_q == ST_FULL) && !ex_kill_in;
    assign fet_ready_out = (state_q != ST_FULL) || (dec_ready_in && dec_valid_out);
    assign fet_accept    = fet_valid_in && fet_ready_out;

    always_comb begin
        entry_d      = '0;
        entry_d.f    = fld_if.fields;
        entry_d.valA = rf_data1_in;
        entry_d.valB = rf_data2_in;
        entry_d.pc   = fet_pc_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            entry_q <= '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    // A kill with nothing held annuls the next word; if that word arrives now, drop it here
                    if (fet_accept && !ex_kill_in) begin
                        state_q <= ST_FULL;
                        entry_q <= entry_d;
                    end else if (ex_kill_in && !fet_accept) begin
                        state_q <= ST_ANNUL_PEND;
                    end
                end
                ST_FULL: begin
                    if (fet_accept) begin
                        entry_q <= entry_d;
                    end else if (ex_kill_in || dec_ready_in) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_ANNUL_PEND: begin
                    if (fet_valid_in) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign dec_op_out      = entry_q.f.op;
    assign dec_op2_out     = entry_q.f.op2;
    assign dec_op3_out     = entry_q.f.op3;
    assign dec_rd_out      = entry_q.f.rd;
    assign dec_cond_out    = entry_q.f.cond;
    assign dec_a_out       = entry_q.f.a;
    assign dec_i_out       = entry_q.f.i;
    assign dec_imm22_out   = entry_q.f.imm22;
    assign dec_simm13_out  = entry_q.f.simm13;
    assign dec_disp30_out  = entry_q.f.disp30;
    assign dec_illegal_out = entry_q.f.illegal;
    assign dec_valA_out    = entry_q.valA;
    assign dec_valB_out    = entry_q.valB;
    assign dec_PC_out      = entry_q.pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: vector table plus handshake/kill/reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fet_valid_in;
    logic        fet_ready_out;
    logic [31:0] fet_inst_in;
    logic [31:0] fet_pc_in;
    logic [4:0]  rf_rs1_out;
    logic [4:0]  rf_rs2_out;
    logic [31:0] rf_data1_in;
    logic [31:0] rf_data2_in;
    logic        ex_kill_in;
    logic        dec_valid_out;
    logic        dec_ready_in;
    logic [1:0]  dec_op_out;
    logic [2:0]  dec_op2_out;
    logic [5:0]  dec_op3_out;
    logic [4:0]  dec_rd_out;
    logic [3:0]  dec_cond_out;
    logic        dec_a_out;
    logic        dec_i_out;
    logic [21:0] dec_imm22_out;
    logic [12:0] dec_simm13_out;
    logic [29:0] dec_disp30_out;
    logic [31:0] dec_valA_out;
    logic [31:0] dec_valB_out;
    logic [31:0] dec_PC_out;
    logic        dec_illegal_out;

    decode_stage dut (
        .clk             (clk),
        .reset           (reset),
        .fet_valid_in    (fet_valid_in),
        .fet_ready_out   (fet_ready_out),
        .fet_inst_in     (fet_inst_in),
        .fet_pc_in       (fet_pc_in),
        .rf_rs1_out      (rf_rs1_out),
        .rf_rs2_out      (rf_rs2_out),
        .rf_data1_in     (rf_data1_in),
        .rf_data2_in     (rf_data2_in),
        .ex_kill_in      (ex_kill_in),
        .dec_valid_out   (dec_valid_out),
        .dec_ready_in    (dec_ready_in),
        .dec_op_out      (dec_op_out),
        .dec_op2_out     (dec_op2_out),
        .dec_op3_out     (dec_op3_out),
        .dec_rd_out      (dec_rd_out),
        .dec_cond_out    (dec_cond_out),
        .dec_a_out       (dec_a_out),
        .dec_i_out       (dec_i_out),
        .dec_imm22_out   (dec_imm22_out),
        .dec_simm13_out  (dec_simm13_out),
        .dec_disp30_out  (dec_disp30_out),
        .dec_valA_out    (dec_valA_out),
        .dec_valB_out    (dec_valB_out),
        .dec_PC_out      (dec_PC_out),
        .dec_illegal_out (dec_illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [1:0]  op;
        logic [2:0]  op2;
        logic [5:0]  op3;
        logic [4:0]  rd;
        logic [3:0]  cond;
        logic        a;
        logic        i;
        logic [21:0] imm22;
        logic [12:0] simm13;
        logic [29:0] disp30;
        logic        ill;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;
    int   xfers  = 0;
    int   xf0;

    always @(posedge clk)
        if (reset && dec_valid_out && dec_ready_in) xfers++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] d1);
        fet_valid_in = 1'b1;
        fet_inst_in  = inst;
        fet_pc_in    = pc;
        rf_data1_in  = d1;
        rf_data2_in  = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            inst          pc            d1            d2            op     op2     op3    rd     cond  a     i     imm22        simm13    disp30          ill   rs1    rs2
        vecs[0] = '{32'h03000010, 32'h00001000, 32'h00000011, 32'h00000022, 2'd0, 3'b100, 6'h20, 5'd1,  4'h1, 1'b0, 1'b0, 22'h000010, 13'h0010, 30'h03000010, 1'b0, 5'd0,  5'd16};
        vecs[1] = '{32'h84007FFF, 32'h00001004, 32'h00000005, 32'h00000077, 2'd2, 3'b000, 6'h00, 5'd2,  4'h2, 1'b0, 1'b1, 22'h007FFF, 13'h1FFF, 30'h04007FFF, 1'b0, 5'd1,  5'd31};
        vecs[2] = '{32'h00000000, 32'h00001008, 32'hDEADBEEF, 32'h12345678, 2'd0, 3'b000, 6'h00, 5'd0,  4'h0, 1'b0, 1'b0, 22'h000000, 13'h0000, 30'h00000000, 1'b1, 5'd0,  5'd0};
        vecs[3] = '{32'h12800005, 32'h0000100C, 32'h00000001, 32'h00000002, 2'd0, 3'b010, 6'h10, 5'd9,  4'h9, 1'b0, 1'b0, 22'h000005, 13'h0005, 30'h12800005, 1'b0, 5'd0,  5'd5};
        vecs[4] = '{32'h86404002, 32'h00001010, 32'hA5A5A5A5, 32'h5A5A5A5A, 2'd2, 3'b001, 6'h08, 5'd3,  4'h3, 1'b0, 1'b0, 22'h004002, 13'h0002, 30'h06404002, 1'b1, 5'd1,  5'd2};
        vecs[5] = '{32'h40000003, 32'h00001014, 32'h00000000, 32'hFFFFFFFF, 2'd1, 3'b000, 6'h00, 5'd0,  4'h0, 1'b0, 1'b0, 22'h000003, 13'h0003, 30'h00000003, 1'b0, 5'd0,  5'd3};
        vecs[6] = '{32'h9DE3BFA0, 32'h00001018, 32'h0000FFF0, 32'h00000000, 2'd2, 3'b111, 6'h3C, 5'd14, 4'hE, 1'b0, 1'b1, 22'h23BFA0, 13'h1FA0, 30'h1DE3BFA0, 1'b0, 5'd14, 5'd0};
        vecs[7] = '{32'h32800005, 32'hFFFFFFFC, 32'h80000000, 32'h00000001, 2'd0, 3'b010, 6'h10, 5'd25, 4'h9, 1'b1, 1'b0, 22'h000005, 13'h0005, 30'h32800005, 1'b0, 5'd0,  5'd5};

        reset = 1'b0;
        fet_valid_in = 1'b0; fet_inst_in = '0; fet_pc_in = '0;
        rf_data1_in = '0; rf_data2_in = '0; ex_kill_in = 1'b0; dec_ready_in = 1'b0;
        tick();
        chk("reset_valid", {31'b0, dec_valid_out}, 32'd0);
        chk("reset_pc", dec_PC_out, 32'd0);
        chk("reset_illegal", {31'b0, dec_illegal_out}, 32'd0);
        chk("reset_ready", {31'b0, fet_ready_out}, 32'd1);
        reset = 1'b1;
        tick();

        // Table: back-to-back accepts with execute always ready
        dec_ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            present(vecs[k].inst, vecs[k].pc, vecs[k].d1);
            rf_data2_in = vecs[k].d2;
            #1;
            chk($sformatf("v%0d_rs1", k), {27'b0, rf_rs1_out}, {27'b0, vecs[k].rs1});
            chk($sformatf("v%0d_rs2", k), {27'b0, rf_rs2_out}, {27'b0, vecs[k].rs2});
            chk($sformatf("v%0d_ready", k), {31'b0, fet_ready_out}, 32'd1);
            tick();
            fet_valid_in = 1'b0;
            chk($sformatf("v%0d_valid", k), {31'b0, dec_valid_out}, 32'd1);
            chk($sformatf("v%0d_op", k), {30'b0, dec_op_out}, {30'b0, vecs[k].op});
            chk($sformatf("v%0d_op2", k), {29'b0, dec_op2_out}, {29'b0, vecs[k].op2});
            chk($sformatf("v%0d_op3", k), {26'b0, dec_op3_out}, {26'b0, vecs[k].op3});
            chk($sformatf("v%0d_rd", k), {27'b0, dec_rd_out}, {27'b0, vecs[k].rd});
            chk($sformatf("v%0d_cond", k), {28'b0, dec_cond_out}, {28'b0, vecs[k].cond});
            chk($sformatf("v%0d_a", k), {31'b0, dec_a_out}, {31'b0, vecs[k].a});
            chk($sformatf("v%0d_i", k), {31'b0, dec_i_out}, {31'b0, vecs[k].i});
            chk($sformatf("v%0d_imm22", k), {10'b0, dec_imm22_out}, {10'b0, vecs[k].imm22});
            chk($sformatf("v%0d_simm13", k), {19'b0, dec_simm13_out}, {19'b0, vecs[k].simm13});
            chk($sformatf("v%0d_disp30", k), {2'b0, dec_disp30_out}, {2'b0, vecs[k].disp30});
            chk($sformatf("v%0d_illegal", k), {31'b0, dec_illegal_out}, {31'b0, vecs[k].ill});
            chk($sformatf("v%0d_valA", k), dec_valA_out, vecs[k].d1);
            chk($sformatf("v%0d_valB", k), dec_valB_out, vecs[k].d2);
            chk($sformatf("v%0d_pc", k), dec_PC_out, vecs[k].pc);
        end
        tick();
        chk("drain_valid", {31'b0, dec_valid_out}, 32'd0);

        // Stall: held entry stable for 3 cycles, upstream blocked, then exactly one transfer
        dec_ready_in = 1'b0;
        present(32'h84007FFF, 32'h00002000, 32'h00000005);
        tick();
        present(32'hFFFFFFFF, 32'h00003000, 32'h00000099);
        xf0 = xfers;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d_valid", c), {31'b0, dec_valid_out}, 32'd1);
            chk($sformatf("hold%0d_fready", c), {31'b0, fet_ready_out}, 32'd0);
            chk($sformatf("hold%0d_rd", c), {27'b0, dec_rd_out}, 32'd2);
            chk($sformatf("hold%0d_valA", c), dec_valA_out, 32'd5);
            chk($sformatf("hold%0d_pc", c), dec_PC_out, 32'h00002000);
            tick();
        end
        fet_valid_in = 1'b0;
        dec_ready_in = 1'b1;
        #1;
        chk("release_fready", {31'b0, fet_ready_out}, 32'd1);
        tick();
        chk("release_xfers", xfers - xf0, 32'd1);
        chk("release_empty", {31'b0, dec_valid_out}, 32'd0);
        tick();
        chk("release_no_more", xfers - xf0, 32'd1);

        // Kill while FULL: entry withdrawn, no transfer
        dec_ready_in = 1'b0;
        present(32'h03000010, 32'h00004000, 32'h0);
        tick();
        fet_valid_in = 1'b0;
        xf0 = xfers;
        ex_kill_in = 1'b1;
        dec_ready_in = 1'b1;
        #1;
        chk("killfull_valid", {31'b0, dec_valid_out}, 32'd0);
        chk("killfull_fready", {31'b0, fet_ready_out}, 32'd0);
        tick();
        ex_kill_in = 1'b0;
        chk("killfull_xfers", xfers - xf0, 32'd0);
        chk("killfull_empty", {31'b0, dec_valid_out}, 32'd0);
        chk("killfull_ready", {31'b0, fet_ready_out}, 32'd1);

        // Kill while EMPTY: next accepted word dropped, following one decoded
        dec_ready_in = 1'b0;
        ex_kill_in = 1'b1;
        tick();
        ex_kill_in = 1'b0;
        present(32'h03000010, 32'h00005000, 32'h0);
        #1;
        chk("annul_ready", {31'b0, fet_ready_out}, 32'd1);
        tick();
        chk("annul_dropped", {31'b0, dec_valid_out}, 32'd0);
        present(32'h84007FFF, 32'h00005004, 32'h00000005);
        tick();
        fet_valid_in = 1'b0;
        chk("annul_next_valid", {31'b0, dec_valid_out}, 32'd1);
        chk("annul_next_rd", {27'b0, dec_rd_out}, 32'd2);
        chk("annul_next_valA", dec_valA_out, 32'd5);
        chk("annul_next_pc", dec_PC_out, 32'h00005004);
        dec_ready_in = 1'b1;
        tick();

        // Kill in EMPTY with same-cycle accept: word dropped, stays EMPTY (next word decoded)
        dec_ready_in = 1'b0;
        ex_kill_in = 1'b1;
        present(32'h03000010, 32'h00006000, 32'h0);
        tick();
        ex_kill_in = 1'b0;
        fet_valid_in = 1'b0;
        chk("killacc_valid", {31'b0, dec_valid_out}, 32'd0);
        present(32'h00000000, 32'h00006004, 32'h0);
        tick();
        fet_valid_in = 1'b0;
        chk("killacc_next_valid", {31'b0, dec_valid_out}, 32'd1);
        chk("killacc_next_illegal", {31'b0, dec_illegal_out}, 32'd1);
        chk("killacc_next_pc", dec_PC_out, 32'h00006004);

        // Reset while FULL: valid drops asynchronously, outputs cleared
        #2;
        reset = 1'b0;
        #1;
        chk("rstfull_valid", {31'b0, dec_valid_out}, 32'd0);
        chk("rstfull_pc", dec_PC_out, 32'd0);
        chk("rstfull_illegal", {31'b0, dec_illegal_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("rstfull_empty_valid", {31'b0, dec_valid_out}, 32'd0);
        chk("rstfull_empty_ready", {31'b0, fet_ready_out}, 32'd1);

        // Reset clears a pending annul
        ex_kill_in = 1'b1;
        tick();
        ex_kill_in = 1'b0;
        #2;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        present(32'h03000010, 32'h00007000, 32'h0);
        tick();
        fet_valid_in = 1'b0;
        chk("rstannul_valid", {31'b0, dec_valid_out}, 32'd1);
        chk("rstannul_pc", dec_PC_out, 32'h00007000);
        dec_ready_in = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
